// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
// Two-port round-robin arbiter in front of a single memory/cache request
// channel. Port 0 carries instruction fetches, port 1 carries data accesses.
// One transaction is in flight at a time: IDLE picks a winner and latches its
// request, BUSY presents it to memory until a response (or timeout), DONE
// delivers a one-cycle completion pulse to the winner.
//
// Ports:
//   sys_clk, rst        clock, asynchronous active-high reset
//   p0_req_*            port 0 request (addr/data/rw/valid)
//   p0_res_data/ready   port 0 response data and one-cycle completion pulse
//   p1_req_*, p1_res_*  same for port 1
//   mem_req_*           shared memory request (addr/data/rw/valid)
//   mem_res_data/ready  memory response, ready is a one-cycle pulse
//   grant               one-hot current owner (bit0 = port 0), 00 when idle
//   timeout_err         sticky flag, set when a transaction is aborted
// -----------------------------------------------------------------------------
module mem_req_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_data,
  input  logic              p0_req_rw,
  input  logic              p0_req_valid,
  output logic [DATA_W-1:0] p0_res_data,
  output logic              p0_res_ready,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_data,
  input  logic              p1_req_rw,
  input  logic              p1_req_valid,
  output logic [DATA_W-1:0] p1_res_data,
  output logic              p1_res_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              mem_req_rw,
  output logic              mem_req_valid,
  input  logic [DATA_W-1:0] mem_res_data,
  input  logic              mem_res_ready,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last BUSY cycle count before the transaction is aborted.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t              r_state,     w_state_nxt;
  logic [1:0]          r_grant,     w_grant_nxt;
  logic                r_last,      w_last_nxt;   // 1 = port 1 granted last
  logic [ADDR_W-1:0]   r_addr,      w_addr_nxt;
  logic [DATA_W-1:0]   r_data,      w_data_nxt;
  logic                r_rw,        w_rw_nxt;
  logic                r_valid,     w_valid_nxt;
  logic [15:0]         r_cnt,       w_cnt_nxt;
  logic [DATA_W-1:0]   r_p0_data,   w_p0_data_nxt;
  logic [DATA_W-1:0]   r_p1_data,   w_p1_data_nxt;
  logic                r_p0_rdy,    w_p0_rdy_nxt;
  logic                r_p1_rdy,    w_p1_rdy_nxt;
  logic                r_tmo,       w_tmo_nxt;

  logic                w_pick1;
  logic                w_finish;
  logic [DATA_W-1:0]   w_res_val;

  // Port 1 wins when it is the only requester, or on a tie when port 0 was
  // granted last.
  assign w_pick1   = p1_req_valid & (~p0_req_valid | ~r_last);
  // A response in the timeout cycle takes priority over the abort.
  assign w_finish  = mem_res_ready | (r_cnt == CNT_LAST);
  assign w_res_val = mem_res_ready ? mem_res_data : {DATA_W{1'b0}};

  // Next-state and next-output logic for the IDLE/BUSY/DONE sequence.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_rw_nxt      = r_rw;
    w_valid_nxt   = r_valid;
    w_cnt_nxt     = r_cnt;
    w_p0_data_nxt = r_p0_data;
    w_p1_data_nxt = r_p1_data;
    w_p0_rdy_nxt  = 1'b0;
    w_p1_rdy_nxt  = 1'b0;
    w_tmo_nxt     = r_tmo;

    case (r_state)
      ST_IDLE: begin
        if (p0_req_valid || p1_req_valid) begin
          w_state_nxt = ST_BUSY;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = 16'd0;
          w_last_nxt  = w_pick1;
          if (w_pick1) begin
            w_grant_nxt = 2'b10;
            w_addr_nxt  = p1_req_addr;
            w_data_nxt  = p1_req_data;
            w_rw_nxt    = p1_req_rw;
          end else begin
            w_grant_nxt = 2'b01;
            w_addr_nxt  = p0_req_addr;
            w_data_nxt  = p0_req_data;
            w_rw_nxt    = p0_req_rw;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (w_finish) begin
          w_state_nxt = ST_DONE;
          w_valid_nxt = 1'b0;
          if (!mem_res_ready) begin
            w_tmo_nxt = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo;
          end
          if (r_grant[1]) begin
            w_p1_data_nxt = w_res_val;
            w_p1_rdy_nxt  = 1'b1;
          end else begin
            w_p0_data_nxt = w_res_val;
            w_p0_rdy_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      ST_DONE: begin
        // Requester valids are deliberately not looked at here.
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
        w_cnt_nxt   = 16'd0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= 2'b00;
      r_last    <= 1'b1;
      r_addr    <= {ADDR_W{1'b0}};
      r_data    <= {DATA_W{1'b0}};
      r_rw      <= 1'b0;
      r_valid   <= 1'b0;
      r_cnt     <= 16'd0;
      r_p0_data <= {DATA_W{1'b0}};
      r_p1_data <= {DATA_W{1'b0}};
      r_p0_rdy  <= 1'b0;
      r_p1_rdy  <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_rw      <= w_rw_nxt;
      r_valid   <= w_valid_nxt;
      r_cnt     <= w_cnt_nxt;
      r_p0_data <= w_p0_data_nxt;
      r_p1_data <= w_p1_data_nxt;
      r_p0_rdy  <= w_p0_rdy_nxt;
      r_p1_rdy  <= w_p1_rdy_nxt;
      r_tmo     <= w_tmo_nxt;
    end
  end

  assign grant         = r_grant;
  assign mem_req_addr  = r_addr;
  assign mem_req_data  = r_data;
  assign mem_req_rw    = r_rw;
  assign mem_req_valid = r_valid;
  assign p0_res_data   = r_p0_data;
  assign p1_res_data   = r_p1_data;
  assign p0_res_ready  = r_p0_rdy;
  assign p1_res_ready  = r_p1_rdy;
  assign timeout_err   = r_tmo;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
// Self-checking bench for mem_req_arbiter (TIMEOUT = 4). Each granted
// transaction pushes its expected completion (port, data) onto a scoreboard;
// a negedge monitor pops and compares whenever a res_ready pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;

  localparam int AW = 27;
  localparam int DW = 32;

  logic          sys_clk;
  logic          rst;
  logic [AW-1:0] p0_req_addr, p1_req_addr, mem_req_addr;
  logic [DW-1:0] p0_req_data, p1_req_data, mem_req_data;
  logic          p0_req_rw, p1_req_rw, mem_req_rw;
  logic          p0_req_valid, p1_req_valid, mem_req_valid;
  logic [DW-1:0] p0_res_data, p1_res_data, mem_res_data;
  logic          p0_res_ready, p1_res_ready, mem_res_ready;
  logic [1:0]    grant;
  logic          timeout_err;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   ok;

  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .p0_req_addr  (p0_req_addr),
    .p0_req_data  (p0_req_data),
    .p0_req_rw    (p0_req_rw),
    .p0_req_valid (p0_req_valid),
    .p0_res_data  (p0_res_data),
    .p0_res_ready (p0_res_ready),
    .p1_req_addr  (p1_req_addr),
    .p1_req_data  (p1_req_data),
    .p1_req_rw    (p1_req_rw),
    .p1_req_valid (p1_req_valid),
    .p1_res_data  (p1_res_data),
    .p1_res_ready (p1_res_ready),
    .mem_req_addr (mem_req_addr),
    .mem_req_data (mem_req_data),
    .mem_req_rw   (mem_req_rw),
    .mem_req_valid(mem_req_valid),
    .mem_res_data (mem_res_data),
    .mem_res_ready(mem_res_ready),
    .grant        (grant),
    .timeout_err  (timeout_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every res_ready pulse must match the scoreboard head.
  always @(negedge sys_clk) begin
    if (!rst && (p0_res_ready || p1_res_ready)) begin
      check_eq("mon_one_hot", 64'(p0_res_ready & p1_res_ready), 64'd0);
      if (sb_q.size() == 0) begin
        check_eq("mon_unexpected_resp", 64'({p1_res_ready, p0_res_ready}), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("mon_port", 64'(p1_res_ready), 64'(mon_e.port));
        check_eq("mon_data", 64'(mon_e.port ? p1_res_data : p0_res_data), 64'(mon_e.data));
      end
    end
  end

  task automatic set_p0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw);
    p0_req_addr = a; p0_req_data = d; p0_req_rw = rw; p0_req_valid = 1'b1;
  endtask

  task automatic set_p1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw);
    p1_req_addr = a; p1_req_data = d; p1_req_rw = rw; p1_req_valid = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] eg, output bit got);
    got = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge sys_clk);
      if (grant != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    check_eq({tag, "_granted"}, 64'(got), 64'd1);
    if (got) check_eq({tag, "_grant"}, 64'(grant), 64'(eg));
  endtask

  // One transaction: wait for grant, check the memory request, scramble the
  // winner's inputs while BUSY, answer after dly BUSY cycles (or not at all),
  // then check the completion pulse and the return to IDLE.
  task automatic run_txn(input string tag, input logic [1:0] eg, input logic erw,
                         input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                         input int dly, input bit respond, input logic [DW-1:0] rdata,
                         input logic [1:0] drop);
    bit   got;
    exp_t e;
    wait_grant(tag, eg, got);
    if (!got) return;
    check_eq({tag, "_mvalid"}, 64'(mem_req_valid), 64'd1);
    check_eq({tag, "_maddr"},  64'(mem_req_addr),  64'(ea));
    check_eq({tag, "_mdata"},  64'(mem_req_data),  64'(ed));
    check_eq({tag, "_mrw"},    64'(mem_req_rw),    64'(erw));
    e.port = eg[1];
    e.data = respond ? rdata : 32'h0000_0000;
    sb_q.push_back(e);
    if (eg[0]) begin
      p0_req_addr = ~p0_req_addr; p0_req_data = ~p0_req_data; p0_req_rw = ~p0_req_rw;
    end else begin
      p1_req_addr = ~p1_req_addr; p1_req_data = ~p1_req_data; p1_req_rw = ~p1_req_rw;
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge sys_clk);
      check_eq({tag, "_busy_valid"}, 64'(mem_req_valid), 64'd1);
      check_eq({tag, "_busy_addr"},  64'(mem_req_addr),  64'(ea));
    end
    if (respond) begin
      mem_res_ready = 1'b1;
      mem_res_data  = rdata;
    end
    @(negedge sys_clk);
    mem_res_ready = 1'b0;
    mem_res_data  = 32'hBAD0_BAD0;
    check_eq({tag, "_rdy"}, 64'(eg[0] ? p0_res_ready : p1_res_ready), 64'd1);
    check_eq({tag, "_done_mvalid"}, 64'(mem_req_valid), 64'd0);
    check_eq({tag, "_done_addr"}, 64'(mem_req_addr), 64'(ea));
    if (eg[0]) begin
      p0_req_addr = ~p0_req_addr; p0_req_data = ~p0_req_data; p0_req_rw = ~p0_req_rw;
    end else begin
      p1_req_addr = ~p1_req_addr; p1_req_data = ~p1_req_data; p1_req_rw = ~p1_req_rw;
    end
    if (drop[0]) p0_req_valid = 1'b0;
    if (drop[1]) p1_req_valid = 1'b0;
    @(negedge sys_clk);
    check_eq({tag, "_rdy_1cyc"}, 64'({p1_res_ready, p0_res_ready}), 64'd0);
    check_eq({tag, "_idle_grant"}, 64'(grant), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    p0_req_addr = '0; p0_req_data = '0; p0_req_rw = 1'b0; p0_req_valid = 1'b0;
    p1_req_addr = '0; p1_req_data = '0; p1_req_rw = 1'b0; p1_req_valid = 1'b0;
    mem_res_data = '0; mem_res_ready = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Reset state
    check_eq("rst_grant",  64'(grant),         64'd0);
    check_eq("rst_mvalid", 64'(mem_req_valid), 64'd0);
    check_eq("rst_maddr",  64'(mem_req_addr),  64'd0);
    check_eq("rst_mdata",  64'(mem_req_data),  64'd0);
    check_eq("rst_mrw",    64'(mem_req_rw),    64'd0);
    check_eq("rst_rdy",    64'({p1_res_ready, p0_res_ready}), 64'd0);
    check_eq("rst_rdata",  64'({p1_res_data, p0_res_data}),   64'd0);
    check_eq("rst_tmo",    64'(timeout_err),   64'd0);
    rst = 1'b0;
    @(negedge sys_clk);

    // Round robin from reset with both ports held: 01, 10, 01
    set_p0(27'h000_0100, 32'h0000_0000, 1'b0);
    set_p1(27'h000_0200, 32'hCAFE_0001, 1'b1);
    run_txn("rr1", 2'b01, 1'b0, 27'h000_0100, 32'h0000_0000, 1, 1'b1, 32'h1111_1111, 2'b00);
    run_txn("rr2", 2'b10, 1'b1, 27'h000_0200, 32'hCAFE_0001, 2, 1'b1, 32'h2222_2222, 2'b00);
    run_txn("rr3", 2'b01, 1'b0, 27'h000_0100, 32'h0000_0000, 0, 1'b1, 32'h3333_0000, 2'b11);

    // Port 0 write alone
    set_p0(27'h2AA_AAAA, 32'h3333_3333, 1'b1);
    run_txn("wr_p0", 2'b01, 1'b1, 27'h2AA_AAAA, 32'h3333_3333, 1, 1'b1, 32'hDEAD_BEEF, 2'b01);

    // Port 1 read alone; port 0 data must hold its last value
    set_p1(27'h123_4567, 32'h0000_0000, 1'b0);
    run_txn("rd_p1", 2'b10, 1'b0, 27'h123_4567, 32'h0000_0000, 0, 1'b1, 32'h0F0F_0F0F, 2'b10);
    check_eq("hold_p0_data", 64'(p0_res_data), 64'hDEAD_BEEF);
    check_eq("p1_data",      64'(p1_res_data), 64'h0F0F_0F0F);

    // Stray memory response while IDLE
    mem_res_ready = 1'b1;
    mem_res_data  = 32'h5555_5555;
    @(negedge sys_clk);
    mem_res_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      check_eq("idle_stray_grant",  64'(grant),         64'd0);
      check_eq("idle_stray_mvalid", 64'(mem_req_valid), 64'd0);
      check_eq("idle_stray_rdy",    64'({p1_res_ready, p0_res_ready}), 64'd0);
      check_eq("idle_stray_p1data", 64'(p1_res_data),   64'h0F0F_0F0F);
    end

    // Response in the timeout cycle wins
    set_p0(27'h000_0003, 32'h0000_0000, 1'b0);
    run_txn("tmo_edge", 2'b01, 1'b0, 27'h000_0003, 32'h0000_0000, 3, 1'b1, 32'hA5A5_A5A5, 2'b01);
    check_eq("tmo_edge_err", 64'(timeout_err), 64'd0);

    // Timeout abort: 4 BUSY cycles, data 0, sticky error
    set_p1(27'h765_4321, 32'h1234_5678, 1'b1);
    run_txn("tmo", 2'b10, 1'b1, 27'h765_4321, 32'h1234_5678, 3, 1'b0, 32'h0000_0000, 2'b10);
    check_eq("tmo_err",    64'(timeout_err), 64'd1);
    check_eq("tmo_p1data", 64'(p1_res_data), 64'd0);

    set_p0(27'h000_0010, 32'h0000_0000, 1'b0);
    run_txn("after_tmo", 2'b01, 1'b0, 27'h000_0010, 32'h0000_0000, 2, 1'b1, 32'h9999_9999, 2'b01);
    check_eq("tmo_sticky", 64'(timeout_err), 64'd1);

    // Reset during BUSY, then a late memory response
    set_p1(27'h000_0044, 32'h0000_0000, 1'b0);
    wait_grant("rst_busy", 2'b10, ok);
    @(negedge sys_clk);
    rst = 1'b1;
    #1;
    check_eq("rstb_grant",  64'(grant),         64'd0);
    check_eq("rstb_mvalid", 64'(mem_req_valid), 64'd0);
    check_eq("rstb_maddr",  64'(mem_req_addr),  64'd0);
    check_eq("rstb_tmo",    64'(timeout_err),   64'd0);
    check_eq("rstb_rdata",  64'({p1_res_data, p0_res_data}), 64'd0);
    p1_req_valid = 1'b0;
    @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    mem_res_ready = 1'b1;
    mem_res_data  = 32'h7777_7777;
    @(negedge sys_clk);
    mem_res_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("late_rdy",    64'({p1_res_ready, p0_res_ready}), 64'd0);
      check_eq("late_grant",  64'(grant),         64'd0);
      check_eq("late_mvalid", 64'(mem_req_valid), 64'd0);
      check_eq("late_p1data", 64'(p1_res_data),   64'd0);
      @(negedge sys_clk);
    end

    // First tie after reset goes to port 0
    set_p0(27'h000_0ABC, 32'h0000_0001, 1'b1);
    set_p1(27'h000_0DEF, 32'h0000_0002, 1'b1);
    run_txn("tie_rst", 2'b01, 1'b1, 27'h000_0ABC, 32'h0000_0001, 1, 1'b1, 32'h4242_4242, 2'b11);

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
